// File: rtl/gemm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// gemm_seq_ctrl
//
// Sequencer for the shared GEMM MAC datapath. It computes
// R = alpha*(A x B) + beta*C one result element at a time, walking the row
// index i, the column index j and the inner index k. For each element it
// issues this strobe sequence into the datapath:
//   clear -> K accumulate cycles -> L drain cycles -> scale -> write
// It then moves to the next element in row-major order.
//
// Ports
//   iclk, irst_n        clock (rising edge) and asynchronous active-low reset
//   start               begin a job; only looked at while idle
//   abort               synchronous cancel of a running job
//   alpha, beta         scale factors, captured when a job starts
//   busy, done          upstream handshake (done is a one-cycle pulse)
//   row_idx, col_idx    current result element (i, j)
//   k_idx               current inner index k
//   mac_clr             zero the accumulator
//   mac_en              accumulate A[i][k]*B[k][j]
//   scale_en            form alpha_q*acc + beta_q*C[i][j]
//   alpha_q, beta_q     captured scale factors, sent on to the datapath
//   wr_valid, wr_ready  write handshake towards the result buffer
//
// All outputs are registered. Each output flop is loaded from the decode of
// the next state, so the outputs line up with the state register without
// any combinational path to the ports.
// -----------------------------------------------------------------------------
module gemm_seq_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int MATRIX_WIDTH  = 4,
    parameter int MATRIX_HEIGHT = 4,
    parameter int MATRIX_ADJUST = 4,
    parameter int MAC_LATENCY   = 2,
    // Index widths are derived from the sizes above; leave them at default.
    parameter int RW = (MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1,
    parameter int CW = (MATRIX_WIDTH  > 1) ? $clog2(MATRIX_WIDTH)  : 1,
    parameter int KW = (MATRIX_ADJUST > 1) ? $clog2(MATRIX_ADJUST) : 1
) (
    input  logic                  iclk,
    input  logic                  irst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] alpha,
    input  logic [DATA_WIDTH-1:0] beta,
    output logic                  busy,
    output logic                  done,
    output logic [RW-1:0]         row_idx,
    output logic [CW-1:0]         col_idx,
    output logic [KW-1:0]         k_idx,
    output logic                  mac_clr,
    output logic                  mac_en,
    output logic                  scale_en,
    output logic [DATA_WIDTH-1:0] alpha_q,
    output logic [DATA_WIDTH-1:0] beta_q,
    output logic                  wr_valid,
    input  logic                  wr_ready
);

    // Width of the drain counter. The counter exists even when
    // MAC_LATENCY is 0, but in that case the drain state is never entered.
    localparam int DCW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

    localparam logic [RW-1:0]  ROW_LAST   = RW'(MATRIX_HEIGHT - 1);
    localparam logic [CW-1:0]  COL_LAST   = CW'(MATRIX_WIDTH - 1);
    localparam logic [KW-1:0]  K_LAST     = KW'(MATRIX_ADJUST - 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'((MAC_LATENCY > 0) ? MAC_LATENCY - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MAC,
        S_DRAIN,
        S_SCALE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state_q,    state_d;
    logic [RW-1:0]         row_q,      row_d;
    logic [CW-1:0]         col_q,      col_d;
    logic [KW-1:0]         k_q,        k_d;
    logic [DCW-1:0]        drain_q,    drain_d;
    logic [DATA_WIDTH-1:0] alpha_d,    beta_d;
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;
    logic                  mac_clr_q,  mac_clr_d;
    logic                  mac_en_q,   mac_en_d;
    logic                  scale_en_q, scale_en_d;
    logic                  wr_valid_q, wr_valid_d;

    // -------------------------------------------------------------------------
    // Next-state and index logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in this block gets a default value
        // first. If some path through the case left a signal unassigned,
        // synthesis would infer a latch for it.
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        k_d     = k_q;
        drain_d = drain_q;
        alpha_d = alpha_q;
        beta_d  = beta_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    alpha_d = alpha;
                    beta_d  = beta;
                    row_d   = '0;
                    col_d   = '0;
                    k_d     = '0;
                    state_d = S_CLEAR;
                end
            end

            S_CLEAR: begin
                k_d     = '0;
                state_d = S_MAC;
            end

            S_MAC: begin
                if (k_q == K_LAST) begin
                    // k goes back to 0 so it reads 0 for the rest of the element.
                    k_d = '0;
                    if (MAC_LATENCY > 0) begin
                        drain_d = '0;
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_SCALE;
                    end
                end else begin
                    k_d = k_q + KW'(1);
                end
            end

            S_DRAIN: begin
                // Wait for the last product to leave the datapath pipeline.
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_SCALE;
                end else begin
                    drain_d = drain_q + DCW'(1);
                end
            end

            S_SCALE: begin
                state_d = S_WRITE;
            end

            S_WRITE: begin
                // The indices stay put until the buffer takes the result.
                if (wr_ready) begin
                    if ((row_q == ROW_LAST) && (col_q == COL_LAST)) begin
                        state_d = S_DONE;
                    end else begin
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                        state_d = S_CLEAR;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort overrides everything above, including a write handshake in
        // the same cycle. The buffer still counts that write as taken. The
        // captured alpha/beta are kept; the next start loads them again.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            row_d   = '0;
            col_d   = '0;
            k_d     = '0;
            drain_d = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Output decode from the next state (registered below)
    // -------------------------------------------------------------------------
    always_comb begin
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        mac_clr_d  = (state_d == S_CLEAR);
        mac_en_d   = (state_d == S_MAC);
        scale_en_d = (state_d == S_SCALE);
        wr_valid_d = (state_d == S_WRITE);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            k_q        <= '0;
            drain_q    <= '0;
            alpha_q    <= '0;
            beta_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mac_clr_q  <= 1'b0;
            mac_en_q   <= 1'b0;
            scale_en_q <= 1'b0;
            wr_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample its
            // pre-edge value. Blocking assignments here would let the order
            // of the statements change the result.
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            k_q        <= k_d;
            drain_q    <= drain_d;
            alpha_q    <= alpha_d;
            beta_q     <= beta_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mac_clr_q  <= mac_clr_d;
            mac_en_q   <= mac_en_d;
            scale_en_q <= scale_en_d;
            wr_valid_q <= wr_valid_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign row_idx  = row_q;
    assign col_idx  = col_q;
    assign k_idx    = k_q;
    assign mac_clr  = mac_clr_q;
    assign mac_en   = mac_en_q;
    assign scale_en = scale_en_q;
    assign wr_valid = wr_valid_q;

endmodule

// File: tb/tb_gemm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gemm_seq_ctrl
//
// Self-checking bench for gemm_seq_ctrl.
//
// The main instance uses the default sizes. A reference model written as
// nested loops over (i, j, k) predicts every output in every cycle, and one
// compare process checks all outputs against it at each falling edge. The
// directed tests also pin the model with hand-computed cycle numbers.
//
// A second, degenerate instance (1x1 result, K=1, L=0) is checked against a
// literal strobe table.
//
// Inputs are driven 1 ns after the rising edge. Outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_gemm_seq_ctrl;

    localparam int DW = 32;
    localparam int H  = 4;
    localparam int W  = 4;
    localparam int K  = 4;
    localparam int L  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start, abort, wr_ready;
    logic [DW-1:0] alpha, beta;
    logic          busy, done, mac_clr, mac_en, scale_en, wr_valid;
    logic [1:0]    row_idx, col_idx, k_idx;
    logic [DW-1:0] alpha_q, beta_q;

    gemm_seq_ctrl #(
        .DATA_WIDTH(DW), .MATRIX_WIDTH(W), .MATRIX_HEIGHT(H),
        .MATRIX_ADJUST(K), .MAC_LATENCY(L)
    ) dut (
        .iclk(clk), .irst_n(rst_n), .start(start), .abort(abort),
        .alpha(alpha), .beta(beta), .busy(busy), .done(done),
        .row_idx(row_idx), .col_idx(col_idx), .k_idx(k_idx),
        .mac_clr(mac_clr), .mac_en(mac_en), .scale_en(scale_en),
        .alpha_q(alpha_q), .beta_q(beta_q),
        .wr_valid(wr_valid), .wr_ready(wr_ready)
    );

    // Degenerate instance: single element, K=1, no drain.
    logic          s_start, s_abort, s_wr_ready;
    logic [DW-1:0] s_alpha, s_beta;
    logic          s_busy, s_done, s_mac_clr, s_mac_en, s_scale_en, s_wr_valid;
    logic [0:0]    s_row_idx, s_col_idx, s_k_idx;
    logic [DW-1:0] s_alpha_q, s_beta_q;

    gemm_seq_ctrl #(
        .DATA_WIDTH(DW), .MATRIX_WIDTH(1), .MATRIX_HEIGHT(1),
        .MATRIX_ADJUST(1), .MAC_LATENCY(0)
    ) dut_small (
        .iclk(clk), .irst_n(rst_n), .start(s_start), .abort(s_abort),
        .alpha(s_alpha), .beta(s_beta), .busy(s_busy), .done(s_done),
        .row_idx(s_row_idx), .col_idx(s_col_idx), .k_idx(s_k_idx),
        .mac_clr(s_mac_clr), .mac_en(s_mac_en), .scale_en(s_scale_en),
        .alpha_q(s_alpha_q), .beta_q(s_beta_q),
        .wr_valid(s_wr_valid), .wr_ready(s_wr_ready)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s @%0t: got=%0h want=%0h", name, $time, act, want);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: one element at a time, phase by phase
    // -------------------------------------------------------------------------
    typedef struct {
        bit            busy;
        bit            done;
        bit            clr;
        bit            en;
        bit            sc;
        bit            wv;
        int            r;
        int            c;
        int            k;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } exp_t;

    exp_t mdl;
    bit   m_rdy;

    task automatic m_set(input bit cl, input bit en, input bit sc, input bit wv,
                         input int r, input int c, input int k);
        mdl.busy = 1'b1;
        mdl.done = 1'b0;
        mdl.clr  = cl;
        mdl.en   = en;
        mdl.sc   = sc;
        mdl.wv   = wv;
        mdl.r    = r;
        mdl.c    = c;
        mdl.k    = k;
    endtask

    task automatic m_idle();
        mdl.busy = 1'b0;
        mdl.done = 1'b0;
        mdl.clr  = 1'b0;
        mdl.en   = 1'b0;
        mdl.sc   = 1'b0;
        mdl.wv   = 1'b0;
    endtask

    // Advance one clock. Report whether the job is cut short by reset or abort.
    task automatic m_adv(output bit stop);
        @(posedge clk);
        m_rdy = wr_ready;
        if (!rst_n) begin
            mdl.a = '0;
            mdl.b = '0;
            stop  = 1'b1;
        end else begin
            stop = abort;
        end
    endtask

    task automatic m_job();
        bit stop;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                m_set(1, 0, 0, 0, r, c, 0);
                m_adv(stop);
                if (stop) return;
                for (int kk = 0; kk < K; kk++) begin
                    m_set(0, 1, 0, 0, r, c, kk);
                    m_adv(stop);
                    if (stop) return;
                end
                for (int d = 0; d < L; d++) begin
                    m_set(0, 0, 0, 0, r, c, 0);
                    m_adv(stop);
                    if (stop) return;
                end
                m_set(0, 0, 1, 0, r, c, 0);
                m_adv(stop);
                if (stop) return;
                do begin
                    m_set(0, 0, 0, 1, r, c, 0);
                    m_adv(stop);
                    if (stop) return;
                end while (!m_rdy);
            end
        end
        m_idle();
        mdl.done = 1'b1;
        m_adv(stop);
    endtask

    initial begin : model
        mdl.a = '0;
        mdl.b = '0;
        mdl.r = 0;
        mdl.c = 0;
        mdl.k = 0;
        forever begin
            m_idle();
            @(posedge clk);
            if (!rst_n) begin
                mdl.a = '0;
                mdl.b = '0;
            end else if (start) begin
                mdl.a = alpha;
                mdl.b = beta;
                m_job();
            end
        end
    end

    // Compare process: all outputs of the main instance, every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy",     64'(busy),     64'(mdl.busy));
            check("done",     64'(done),     64'(mdl.done));
            check("mac_clr",  64'(mac_clr),  64'(mdl.clr));
            check("mac_en",   64'(mac_en),   64'(mdl.en));
            check("scale_en", 64'(scale_en), 64'(mdl.sc));
            check("wr_valid", 64'(wr_valid), 64'(mdl.wv));
            check("alpha_q",  64'(alpha_q),  64'(mdl.a));
            check("beta_q",   64'(beta_q),   64'(mdl.b));
            if (mdl.busy) begin
                check("row_idx", 64'(row_idx), 64'(mdl.r));
                check("col_idx", 64'(col_idx), 64'(mdl.c));
                check("k_idx",   64'(k_idx),   64'(mdl.k));
            end
        end
    end

    // Write/done log, with times relative to the edge that accepted start.
    typedef struct {
        int rel;
        int r;
        int c;
    } wr_t;

    wr_t wq[$];
    int  done_cnt = 0;
    int  done_rel = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_valid && wr_ready) wq.push_back('{cyc - t0, int'(row_idx), int'(col_idx)});
            if (done) begin
                done_cnt = done_cnt + 1;
                done_rel = cyc - t0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    int wb = 0;
    int db = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int n);
        while (cyc - t0 < n) step();
    endtask

    task automatic start_job(input bit hold);
        wb    = wq.size();
        db    = done_cnt;
        t0    = cyc;
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string nm);
        int n = 0;
        while ((done_cnt == db) && (n < limit)) begin
            step();
            n++;
        end
        check(nm, 64'(done_cnt - db), 64'd1);
    endtask

    function automatic int w_rel(input int i);
        return (wb + i < wq.size()) ? wq[wb+i].rel : -1;
    endfunction

    function automatic int w_rc(input int i);
        return (wb + i < wq.size()) ? wq[wb+i].r * W + wq[wb+i].c : -1;
    endfunction

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [5:0] s_tbl [6];

    initial begin : stim
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        wr_ready   = 1'b1;
        alpha      = '0;
        beta       = '0;
        s_start    = 1'b0;
        s_abort    = 1'b0;
        s_wr_ready = 1'b1;
        s_alpha    = '0;
        s_beta     = '0;

        // Reset state
        repeat (3) step();
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_done",     64'(done),     64'd0);
        check("rst_wr_valid", 64'(wr_valid), 64'd0);
        check("rst_row",      64'(row_idx),  64'd0);
        check("rst_alpha_q",  64'(alpha_q),  64'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // Degenerate sizes: CLEAR, MAC, SCALE, WRITE in cycles 1-4, done in 5.
        // Columns: {mac_clr, mac_en, scale_en, wr_valid, done, busy}
        s_tbl[0] = 6'b100001;
        s_tbl[1] = 6'b010001;
        s_tbl[2] = 6'b001001;
        s_tbl[3] = 6'b000101;
        s_tbl[4] = 6'b000010;
        s_tbl[5] = 6'b000000;
        s_alpha  = 32'h0000_0005;
        s_beta   = 32'h0000_0006;
        s_start  = 1'b1;
        step();
        s_start  = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check($sformatf("t6_cycle%0d", n + 1),
                  64'({s_mac_clr, s_mac_en, s_scale_en, s_wr_valid, s_done, s_busy}),
                  64'(s_tbl[n]));
            step();
        end
        check("t6_alpha_q", 64'(s_alpha_q), 64'h5);
        check("t6_beta_q",  64'(s_beta_q),  64'h6);

        // Test 1: full job, wr_ready always high
        alpha = 32'h0000_0011;
        beta  = 32'h0000_0022;
        start_job(0);
        wait_done(400, "t1_done_seen");
        repeat (5) step();
        check("t1_writes",    64'(wq.size() - wb), 64'd16);
        check("t1_first_cyc", 64'(w_rel(0)),  64'd9);
        check("t1_e1_cyc",    64'(w_rel(1)),  64'd18);
        check("t1_e6_cyc",    64'(w_rel(6)),  64'd63);
        check("t1_last_cyc",  64'(w_rel(15)), 64'd144);
        check("t1_done_cyc",  64'(done_rel),  64'd145);
        check("t1_done_once", 64'(done_cnt - db), 64'd1);
        for (int i = 0; i < H * W; i++) check($sformatf("t1_order%0d", i), 64'(w_rc(i)), 64'(i));
        check("t1_alpha_q", 64'(alpha_q), 64'h11);
        check("t1_beta_q",  64'(beta_q),  64'h22);

        // Test 2: wr_ready low for 5 cycles while element (1,2) is offered
        alpha = 32'h0000_0003;
        beta  = 32'h0000_0004;
        start_job(0);
        go(63);
        wr_ready = 1'b0;
        go(68);
        wr_ready = 1'b1;
        wait_done(400, "t2_done_seen");
        repeat (3) step();
        check("t2_writes",   64'(wq.size() - wb), 64'd16);
        check("t2_e5_cyc",   64'(w_rel(5)),  64'd54);
        check("t2_e6_cyc",   64'(w_rel(6)),  64'd68);
        check("t2_e6_rc",    64'(w_rc(6)),   64'd6);
        check("t2_e7_cyc",   64'(w_rel(7)),  64'd77);
        check("t2_last_cyc", 64'(w_rel(15)), 64'd149);
        check("t2_done_cyc", 64'(done_rel),  64'd150);

        // Test 3: abort in cycle 40, while element 4 is in its MAC phase
        start_job(0);
        go(40);
        abort = 1'b1;
        go(41);
        abort = 1'b0;
        @(negedge clk);
        check("t3_busy_41", 64'(busy), 64'd0);
        repeat (40) step();
        check("t3_writes",   64'(wq.size() - wb), 64'd4);
        check("t3_no_done",  64'(done_cnt - db),  64'd0);
        check("t3_wr_valid", 64'(wr_valid), 64'd0);

        // Test 5: start held through the job, alpha/beta changed mid-job.
        // The job after the abort starts again from (0,0).
        alpha = 32'hA5A5_0001;
        beta  = 32'h0000_BEEF;
        start_job(1);
        go(50);
        alpha = 32'hDEAD_DEAD;
        beta  = 32'h1234_5678;
        go(140);
        start = 1'b0;
        wait_done(400, "t5_done_seen");
        repeat (10) step();
        check("t5_writes",    64'(wq.size() - wb), 64'd16);
        check("t5_first_cyc", 64'(w_rel(0)), 64'd9);
        check("t5_first_rc",  64'(w_rc(0)),  64'd0);
        check("t5_done_cyc",  64'(done_rel), 64'd145);
        check("t5_done_once", 64'(done_cnt - db), 64'd1);
        check("t5_alpha_q",   64'(alpha_q), 64'hA5A5_0001);
        check("t5_beta_q",    64'(beta_q),  64'h0000_BEEF);
        check("t5_idle",      64'(busy),    64'd0);

        // Test 4: reset pulse during the drain of element (0,1)
        alpha = 32'h0000_0007;
        beta  = 32'h0000_0009;
        start_job(0);
        go(15);
        #1;
        rst_n = 1'b0;
        #1;
        check("t4_busy",     64'(busy),     64'd0);
        check("t4_col",      64'(col_idx),  64'd0);
        check("t4_alpha_q",  64'(alpha_q),  64'd0);
        check("t4_beta_q",   64'(beta_q),   64'd0);
        check("t4_strobes",  64'({mac_clr, mac_en, scale_en, wr_valid, done}), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        check("t4_no_done", 64'(done_cnt - db), 64'd0);
        start_job(0);
        wait_done(400, "t4_done_seen");
        repeat (3) step();
        check("t4_writes",   64'(wq.size() - wb), 64'd16);
        check("t4_last_cyc", 64'(w_rel(15)), 64'd144);
        check("t4_last_rc",  64'(w_rc(15)),  64'd15);
        check("t4_done_cyc", 64'(done_rel),  64'd145);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
